nes_pixel_streamer: RTL and testbench
=====================================

// Module: nes_pixel_streamer
// PURPOSE
//  Producer end of the PPU->VGA pixel stream. Collects one scanline of 6-bit NES colour codes from the
//  PPU pixel pipeline into a ping-pong line buffer, then drains it in x-order into the video
//  dual-clock FIFO write port (c_code_cpu/cpu_write), throttled by the FIFO almost-full flag.
//  Sits in the cpu_clk domain between the PPU renderer and the VGA stream block.
// PARAMETERS
//  H_PIXELS  256   pixels per scanline (line buffer depth per bank)
//  V_LINES   240   visible scanlines per frame
//  CODE_W    6     colour code width
// PORTS
//  cpu_clk      in   1       system clock; every flop on its rising edge
//  reset_n      in   1       asynchronous, active-low reset
//  enable       in   1       0: drain FSM frozen in IDLE; fill side still accepts pixels
//  pix_valid    in   1       pixel strobe from PPU
//  pix_x        in   8       pixel column, 0..H_PIXELS-1
//  pix_code     in   CODE_W  NES colour code
//  line_done    in   1       1-cycle pulse: the fill bank holds a complete line
//  frame_start  in   1       1-cycle pulse: next drained line is line 0
//  fifo_afull   in   1       FIFO almost full; asserted with >=2 free entries remaining
//  c_code_cpu   out  CODE_W  colour code to FIFO
//  cpu_write    out  1       FIFO write strobe, one code per cycle high
//  line_cnt     out  8       index of the line currently being drained
//  frame_done   out  1       1-cycle pulse after the last pixel of line V_LINES-1 is written
//  overflow     out  1       sticky: line_done arrived while both banks were busy
// BEHAVIOUR
//  Reset: c_code_cpu=0, cpu_write=0, line_cnt=0, frame_done=0, overflow=0, fill_bank=0,
//   both banks not-ready, FSM=IDLE, rd_ptr=0.
//  Fill: pix_valid writes pix_code into bank[fill_bank][pix_x]; x >= H_PIXELS is ignored.
//  line_done with the other bank not-ready: mark fill bank ready, toggle fill_bank.
//   With the other bank still ready/draining: set overflow; do not toggle;
//   the fill bank is overwritten by the next line (line dropped).
//  FSM states: IDLE, DRAIN, FLUSH.
//   IDLE -> DRAIN when enable && a bank is ready; that bank latched as drain bank, rd_ptr=0.
//   DRAIN: each cycle with !fifo_afull issues a sync read of bank[rd_ptr], rd_ptr++;
//    when the read of rd_ptr=H_PIXELS-1 issues -> FLUSH.
//   FLUSH: wait one cycle for the final read data -> IDLE; drain bank set not-ready;
//    line_cnt++ (wraps V_LINES-1 -> 0, pulsing frame_done in the same cycle).
//  Latency: cpu_write/c_code_cpu are registered, 1 cycle after the read issues; exactly
//   H_PIXELS writes per line. If fifo_afull rises, the one read already in flight still
//   writes (hence the >=2 margin); no new read issues while fifo_afull=1.
//  frame_start: sets line_cnt=0 at the next IDLE entry; the current line completes first.
//   frame_start coincident with the wrap means line_cnt=0 with frame_done still pulsed.
//  enable=0 in DRAIN: the line finishes; the FSM then holds in IDLE.
//  line_done and the drain-complete on the same cycle: the bank freed by FLUSH counts as
//   not-ready for that line_done (no overflow).
//  reset_n low mid-line: all state returns to reset values immediately; partial line discarded.
// STRUCTURE
//  Package nes_video_pkg: CODE_W, H_PIXELS, V_LINES, colour_code_t (logic [5:0]),
//   streamer_state_e {IDLE,DRAIN,FLUSH}.
//  Sub-module nes_line_buffer: 2-bank simple dual-port RAM, 1 write port / 1 registered read port.
//  Top holds the bank-ready flags, drain FSM, counters and output register.
// TESTING
//  Fill bank0 with code=x&6'h3F, line_done, fifo_afull=0 -> 256 consecutive writes 0x00..0x3F repeating.
//  Same line, fifo_afull toggled every 3 cycles -> same 256 codes in order, none lost or duplicated.
//  Three line_done pulses with fifo_afull=1 held -> overflow=1 after the third, cpu_write stays 0.
//  Stream 240 lines -> frame_done pulses once, after line 239 last write; line_cnt returns to 0.
//  frame_start mid-line 17 -> line 17 completes (256 writes), next drained line has line_cnt=0.
//  reset_n low at pixel 100 of a drain -> cpu_write=0 same cycle; after release, no writes until a new line_done.

Source files
------------

// File: rtl/nes_video_pkg.sv
// Shared types and geometry for the NES PPU -> VGA pixel path.
package nes_video_pkg;

    localparam int unsigned H_PIXELS = 256;
    localparam int unsigned V_LINES  = 240;
    localparam int unsigned CODE_W   = 6;

    typedef logic [CODE_W-1:0] colour_code_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } streamer_state_e;

    // Line index following 'line', wrapping at the last visible line.
    function automatic logic [7:0] next_line(input logic [7:0] line);
        if (line == 8'(V_LINES - 1)) begin
            return 8'd0;
        end else begin
            return line + 8'd1;
        end
    endfunction

endpackage

// File: rtl/nes_pixel_streamer_if.sv
// FIFO write-side bus between the pixel streamer (master) and the video dual-clock FIFO (slave).
interface nes_pixel_streamer_if;
    import nes_video_pkg::*;

    colour_code_t c_code_cpu;
    logic         cpu_write;
    logic         fifo_afull;

    modport master (output c_code_cpu, output cpu_write, input fifo_afull);
    modport slave  (input c_code_cpu, input cpu_write, output fifo_afull);

endinterface

// File: rtl/nes_line_buffer.sv
// Two-bank scanline RAM: one write port, one registered read port whose register also
// serves as the colour code output toward the FIFO.
module nes_line_buffer
    import nes_video_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic         wr_bank,
    input  logic [7:0]   wr_addr,
    input  colour_code_t wr_data,
    input  logic         rd_en,
    input  logic         rd_bank,
    input  logic [7:0]   rd_addr,
    output colour_code_t rd_data
);

    colour_code_t mem_r [2*H_PIXELS];
    colour_code_t rd_data_r;

    // Pixel write into the selected bank.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    // Synchronous read; the register holds its value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= {CODE_W{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[{rd_bank, rd_addr}];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/nes_pixel_streamer.sv
// Collects PPU scanlines into a ping-pong line buffer and drains each complete line,
// in x order, into the video FIFO write port under almost-full back-pressure.
module nes_pixel_streamer
    import nes_video_pkg::*;
(
    input  logic                 cpu_clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 pix_valid,
    input  logic [7:0]           pix_x,
    input  colour_code_t         pix_code,
    input  logic                 line_done,
    input  logic                 frame_start,
    nes_pixel_streamer_if.master fifo,
    output logic [7:0]           line_cnt,
    output logic                 frame_done,
    output logic                 overflow
);

    streamer_state_e state_r;
    logic            fill_bank_r;
    logic            drain_bank_r;
    logic [1:0]      ready_r;
    logic [7:0]      rd_ptr_r;
    logic [7:0]      line_cnt_r;
    logic            cpu_write_r;
    logic            frame_done_r;
    logic            overflow_r;
    logic            fs_pend_r;

    logic            pix_wr_s;
    logic            rd_issue_s;
    logic [1:0]      ready_freed_s;
    logic [1:0]      ready_nxt_s;
    logic            other_busy_s;
    logic            accept_s;
    colour_code_t    rd_code_s;

    assign pix_wr_s = pix_valid && ({1'b0, pix_x} < 9'(H_PIXELS));

    nes_line_buffer u_line_buffer (
        .clk     (cpu_clk),
        .rst_n   (reset_n),
        .wr_en   (pix_wr_s),
        .wr_bank (fill_bank_r),
        .wr_addr (pix_x),
        .wr_data (pix_code),
        .rd_en   (rd_issue_s),
        .rd_bank (drain_bank_r),
        .rd_addr (rd_ptr_r),
        .rd_data (rd_code_s)
    );

    // Read issue and bank bookkeeping; a bank released in FLUSH is already free for a same-cycle line_done.
    always_comb begin
        rd_issue_s    = 1'b0;
        ready_freed_s = ready_r;
        if (state_r == DRAIN) begin
            rd_issue_s = !fifo.fifo_afull;
        end else begin
            rd_issue_s = 1'b0;
        end
        if (state_r == FLUSH) begin
            ready_freed_s[drain_bank_r] = 1'b0;
        end else begin
            ready_freed_s = ready_r;
        end
        other_busy_s = ready_freed_s[~fill_bank_r];
        accept_s     = line_done && !other_busy_s;
        ready_nxt_s  = ready_freed_s;
        if (accept_s) begin
            ready_nxt_s[fill_bank_r] = 1'b1;
        end else begin
            ready_nxt_s = ready_freed_s;
        end
    end

    // Drain FSM, bank flags, line counter and registered outputs.
    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            fill_bank_r  <= 1'b0;
            drain_bank_r <= 1'b0;
            ready_r      <= 2'b00;
            rd_ptr_r     <= 8'd0;
            line_cnt_r   <= 8'd0;
            cpu_write_r  <= 1'b0;
            frame_done_r <= 1'b0;
            overflow_r   <= 1'b0;
            fs_pend_r    <= 1'b0;
        end else begin
            cpu_write_r  <= rd_issue_s;
            frame_done_r <= 1'b0;
            ready_r      <= ready_nxt_s;
            if (accept_s) begin
                fill_bank_r <= ~fill_bank_r;
            end
            if (line_done && other_busy_s) begin
                overflow_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (frame_start || fs_pend_r) begin
                        line_cnt_r <= 8'd0;
                        fs_pend_r  <= 1'b0;
                    end
                    if (enable && (ready_r != 2'b00)) begin
                        state_r      <= DRAIN;
                        drain_bank_r <= ready_r[1];
                        rd_ptr_r     <= 8'd0;
                    end
                end
                DRAIN: begin
                    if (frame_start) begin
                        fs_pend_r <= 1'b1;
                    end
                    if (rd_issue_s) begin
                        rd_ptr_r <= rd_ptr_r + 8'd1;
                        if (rd_ptr_r == 8'(H_PIXELS - 1)) begin
                            state_r <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    state_r      <= IDLE;
                    frame_done_r <= (line_cnt_r == 8'(V_LINES - 1));
                    line_cnt_r   <= (frame_start || fs_pend_r) ? 8'd0 : next_line(line_cnt_r);
                    fs_pend_r    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign fifo.c_code_cpu = rd_code_s;
    assign fifo.cpu_write  = cpu_write_r;
    assign line_cnt        = line_cnt_r;
    assign frame_done      = frame_done_r;
    assign overflow        = overflow_r;

endmodule

// File: tb/tb_nes_pixel_streamer.sv
// Self-checking bench: randomized scanlines against a line-level reference model of the streamer.
module tb_nes_pixel_streamer;
    import nes_video_pkg::*;

    logic         cpu_clk = 1'b0;
    logic         reset_n;
    logic         enable;
    logic         pix_valid;
    logic [7:0]   pix_x;
    colour_code_t pix_code;
    logic         line_done;
    logic         frame_start;
    logic [7:0]   line_cnt;
    logic         frame_done;
    logic         overflow;

    nes_pixel_streamer_if fifo_bus();

    nes_pixel_streamer dut (
        .cpu_clk     (cpu_clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_code    (pix_code),
        .line_done   (line_done),
        .frame_start (frame_start),
        .fifo        (fifo_bus),
        .line_cnt    (line_cnt),
        .frame_done  (frame_done),
        .overflow    (overflow)
    );

    always #5 cpu_clk = ~cpu_clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model: the line being assembled, the codes still owed to the FIFO, line bookkeeping.
    colour_code_t fill_line [H_PIXELS];
    colour_code_t exp_q [$];
    int  rem = 0;
    int  m_idx = 0;
    bit  m_pend = 1'b0;
    bit  m_ovf = 1'b0;
    bit  fd_exp = 1'b0;
    bit  prev_afull = 1'b0;
    int  wr_seen = 0;
    int  fd_seen = 0;
    int  afull_mode = 0;
    bit  fs_armed = 1'b0;
    int  fs_line = -1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor + model, evaluated mid-cycle with this cycle's inputs and outputs.
    always @(negedge cpu_clk) begin
        if (!reset_n) begin
            exp_q.delete();
            rem = 0; m_idx = 0; m_pend = 1'b0; m_ovf = 1'b0; fd_exp = 1'b0;
        end else begin
            check_val("frame_done", frame_done, fd_exp);
            check_val("overflow", overflow, m_ovf);
            if (frame_done) fd_seen++;
            fd_exp = 1'b0;
            if (fifo_bus.cpu_write) begin
                wr_seen++;
                check_val("write_after_afull", prev_afull, 0);
                if (exp_q.size() == 0) begin
                    check_val("spurious_write", fifo_bus.cpu_write, 0);
                end else begin
                    check_val("code", fifo_bus.c_code_cpu, exp_q.pop_front());
                    check_val("line_cnt", line_cnt, m_idx);
                    rem--;
                    if (rem == 0) begin
                        fd_exp = (m_idx == V_LINES - 1);
                        m_idx  = (m_pend || frame_start) ? 0 : (m_idx + 1) % V_LINES;
                        m_pend = 1'b0;
                    end else if (frame_start) begin
                        m_pend = 1'b1;
                    end
                end
            end else if (frame_start) begin
                if (rem == 0) begin
                    m_idx = 0; m_pend = 1'b0;
                end else begin
                    m_pend = 1'b1;
                end
            end
            if (pix_valid) fill_line[pix_x] = pix_code;
            if (line_done) begin
                if (rem > 0) begin
                    m_ovf = 1'b1;
                end else begin
                    for (int x = 0; x < H_PIXELS; x++) exp_q.push_back(fill_line[x]);
                    rem = H_PIXELS;
                end
            end
        end
        prev_afull = fifo_bus.fifo_afull;
    end

    // Almost-full pattern generator.
    initial begin
        int cnt;
        cnt = 0;
        fifo_bus.fifo_afull = 1'b0;
        forever begin
            @(posedge cpu_clk); #1;
            case (afull_mode)
                1: begin
                    if (cnt % 3 == 0) fifo_bus.fifo_afull = ~fifo_bus.fifo_afull;
                    cnt++;
                end
                2:       fifo_bus.fifo_afull = ($urandom_range(0, 3) == 0);
                3:       fifo_bus.fifo_afull = 1'b1;
                default: fifo_bus.fifo_afull = 1'b0;
            endcase
        end
    end

    task automatic step();
        @(posedge cpu_clk); #1;
    endtask

    task automatic fill(input bit rnd, input int gap_pct);
        for (int x = 0; x < H_PIXELS; x++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                pix_valid = 1'b0; frame_start = 1'b0;
                step();
            end
            pix_valid = 1'b1;
            pix_x     = 8'(x);
            pix_code  = rnd ? colour_code_t'($urandom) : colour_code_t'(x & 63);
            frame_start = fs_armed && (m_idx == fs_line) && (x == 100) && (rem > 16) && (rem < 240);
            if (frame_start) fs_armed = 1'b0;
            step();
        end
        pix_valid = 1'b0; frame_start = 1'b0;
    endtask

    task automatic pulse_ld();
        line_done = 1'b1;
        step();
        line_done = 1'b0;
    endtask

    // early=1 releases line_done on the cycle of the final write of the line in flight.
    task automatic wait_drained(input bit early, input int budget);
        int n;
        bit busy;
        n = 0;
        busy = (early && afull_mode == 0) ? (rem > 1) : (rem > 0);
        while (busy && n < budget) begin
            step(); n++;
            busy = (early && afull_mode == 0) ? (rem > 1) : (rem > 0);
        end
        check_val("drain_timeout", busy, 0);
    endtask

    task automatic stream(input int lines, input bit rnd, input int gap_pct, input bit early);
        for (int i = 0; i < lines; i++) begin
            fill(rnd, gap_pct);
            wait_drained(early, 2000);
            pulse_ld();
        end
        wait_drained(1'b0, 3000);
    endtask

    initial begin
        int base;
        int fd_base;
        int n;
        reset_n = 1'b0; enable = 1'b1; pix_valid = 1'b0; pix_x = 8'd0; pix_code = 6'd0;
        line_done = 1'b0; frame_start = 1'b0;
        repeat (3) step();
        check_val("rst_cpu_write", fifo_bus.cpu_write, 0);
        check_val("rst_code", fifo_bus.c_code_cpu, 0);
        check_val("rst_line_cnt", line_cnt, 0);
        check_val("rst_frame_done", frame_done, 0);
        check_val("rst_overflow", overflow, 0);
        reset_n = 1'b1;
        step();

        // x-pattern line, free-running FIFO, then with almost-full toggling every 3 cycles
        fill(1'b0, 0); pulse_ld(); wait_drained(1'b0, 1000);
        afull_mode = 1; fill(1'b0, 0); pulse_ld(); wait_drained(1'b0, 2000); afull_mode = 0;

        // random lines with random back-pressure, then back-to-back lines hitting the FLUSH boundary
        afull_mode = 2; stream(4, 1'b1, 10, 1'b0); afull_mode = 0;
        stream(3, 1'b1, 0, 1'b1);

        // enable low holds the drain; dropping enable mid-line lets the line finish
        enable = 1'b0; fill(1'b1, 0); pulse_ld();
        base = wr_seen; repeat (300) step();
        check_val("enable_hold", wr_seen - base, 0);
        enable = 1'b1;
        n = 0;
        while (rem > 150 && n < 1000) begin step(); n++; end
        enable = 1'b0;
        wait_drained(1'b0, 1000);
        check_val("line_finish_writes", wr_seen - base, H_PIXELS);
        fill(1'b1, 0); pulse_ld();
        base = wr_seen; repeat (50) step();
        check_val("enable_hold2", wr_seen - base, 0);
        enable = 1'b1; wait_drained(1'b0, 1000);

        // three lines against a full FIFO
        afull_mode = 3; repeat (2) step();
        base = wr_seen;
        for (int i = 0; i < 3; i++) begin fill(1'b1, 0); pulse_ld(); end
        step();
        check_val("overflow_sticky", overflow, 1);
        check_val("afull_no_write", wr_seen - base, 0);
        afull_mode = 0; wait_drained(1'b0, 1000);

        // reset asserted part-way through a drain
        fill(1'b1, 0); pulse_ld();
        n = 0;
        while (rem > H_PIXELS - 100 && n < 1000) begin step(); n++; end
        reset_n = 1'b0; #1;
        check_val("mid_rst_cpu_write", fifo_bus.cpu_write, 0);
        check_val("mid_rst_line_cnt", line_cnt, 0);
        check_val("mid_rst_overflow", overflow, 0);
        check_val("mid_rst_code", fifo_bus.c_code_cpu, 0);
        repeat (3) step();
        reset_n = 1'b1;
        base = wr_seen; repeat (600) step();
        check_val("no_write_after_rst", wr_seen - base, 0);

        // lines 0..17 with frame_start during line 17, then a full 240-line frame
        fs_armed = 1'b1; fs_line = 17; fd_base = fd_seen;
        stream(18 + V_LINES, 1'b1, 0, 1'b1);
        step();
        check_val("frame_start_taken", fs_armed, 0);
        check_val("frame_done_pulses", fd_seen - fd_base, 1);
        check_val("line_cnt_wrap", line_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
